// File: rtl/pe_lin_pkg.sv
// Definitions shared by PE_Lin, its activation-side feeder and their benches.
package pe_lin_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 12;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_HOLD   = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/act_buf.sv
// Activation buffer: DEPTH x DATA_W register array, one write port, one combinational read port.
module act_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Storage write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/pe_lin_feeder.sv
// Streams buffered activations into one PE_Lin, waits out its output latency,
// then captures the four accumulators and offers them on a valid/ready handshake.
module pe_lin_feeder
  import pe_lin_pkg::*;
#(
  parameter int DATA_W = pe_lin_pkg::DATA_W,
  parameter int ACC_W  = pe_lin_pkg::ACC_W,
  parameter int DEPTH  = 16,
  parameter int DRAIN  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       start,
  input  logic [$clog2(DEPTH):0]     len,
  output logic                       busy,
  output logic                       pe_fire,
  output logic [DATA_W-1:0]          pe_a,
  input  logic [ACC_W-1:0]           pe_o1,
  input  logic [ACC_W-1:0]           pe_o2,
  input  logic [ACC_W-1:0]           pe_o3,
  input  logic [ACC_W-1:0]           pe_o4,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ACC_W-1:0]           res_o1,
  output logic [ACC_W-1:0]           res_o2,
  output logic [ACC_W-1:0]           res_o3,
  output logic [ACC_W-1:0]           res_o4
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = IDX_W + 1;
  localparam int DRN_W = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  feeder_state_t     state_r, state_s;
  logic [IDX_W-1:0]  idx_r, idx_s, rd_addr_s;
  logic [LEN_W-1:0]  len_r, len_s;
  logic [DRN_W-1:0]  cnt_r, cnt_s;
  logic              busy_s, fire_s, valid_s, cap_s, buf_we_s;
  logic [DATA_W-1:0] a_s, rd_data_s, first_s;

  assign buf_we_s = wr_en && (state_r == S_IDLE) && !rst;
  // pe_a is registered, so the read address runs one entry ahead of idx_r.
  assign rd_addr_s = (state_r == S_IDLE) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
  // A write landing on entry 0 in the start cycle must be seen by that run.
  assign first_s = (wr_en && wr_addr == {IDX_W{1'b0}}) ? wr_data : rd_data_s;

  act_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(IDX_W)) u_buf (
    .clk     (clk),
    .wr_en   (buf_we_s),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    len_s   = len_r;
    cnt_s   = cnt_r;
    busy_s  = busy;
    fire_s  = pe_fire;
    a_s     = pe_a;
    valid_s = res_valid;
    cap_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start && len != {LEN_W{1'b0}}) begin
          state_s = S_STREAM;
          idx_s   = {IDX_W{1'b0}};
          len_s   = (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
          busy_s  = 1'b1;
          fire_s  = 1'b1;
          a_s     = first_s;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_STREAM: begin
        if ({1'b0, idx_r} == len_r - LEN_W'(1)) begin
          state_s = S_DRAIN;
          cnt_s   = DRN_W'(DRAIN - 1);
          fire_s  = 1'b0;
          a_s     = {DATA_W{1'b0}};
        end else begin
          idx_s = idx_r + IDX_W'(1);
          a_s   = rd_data_s;
        end
      end
      S_DRAIN: begin
        if (cnt_r == {DRN_W{1'b0}}) begin
          state_s = S_HOLD;
          cap_s   = 1'b1;
          valid_s = 1'b1;
        end else begin
          cnt_s = cnt_r - DRN_W'(1);
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          state_s = S_IDLE;
          busy_s  = 1'b0;
          valid_s = 1'b0;
        end else begin
          state_s = S_HOLD;
        end
      end
      default: begin
        state_s = S_IDLE;
        busy_s  = 1'b0;
        fire_s  = 1'b0;
        a_s     = {DATA_W{1'b0}};
        valid_s = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Counters, registered outputs and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r     <= {IDX_W{1'b0}};
      len_r     <= {LEN_W{1'b0}};
      cnt_r     <= {DRN_W{1'b0}};
      busy      <= 1'b0;
      pe_fire   <= 1'b0;
      pe_a      <= {DATA_W{1'b0}};
      res_valid <= 1'b0;
      res_o1    <= {ACC_W{1'b0}};
      res_o2    <= {ACC_W{1'b0}};
      res_o3    <= {ACC_W{1'b0}};
      res_o4    <= {ACC_W{1'b0}};
    end else begin
      idx_r     <= idx_s;
      len_r     <= len_s;
      cnt_r     <= cnt_s;
      busy      <= busy_s;
      pe_fire   <= fire_s;
      pe_a      <= a_s;
      res_valid <= valid_s;
      if (cap_s) begin
        res_o1 <= pe_o1;
        res_o2 <= pe_o2;
        res_o3 <= pe_o3;
        res_o4 <= pe_o4;
      end
    end
  end

endmodule

// File: tb/tb_pe_lin_feeder.sv
// Self-checking bench for pe_lin_feeder with a behavioural PE_Lin and a reference run model.
module tb_pe_lin_feeder;

  localparam int DATA_W  = 8;
  localparam int ACC_W   = 12;
  localparam int DEPTH_P = 16;
  localparam int DRAIN_P = 2;

  logic              clk = 1'b0;
  logic              rst, wr_en, start, res_ready, pe_clr;
  logic [3:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [4:0]        len;
  logic              busy, pe_fire, res_valid;
  logic [DATA_W-1:0] pe_a;
  logic [ACC_W-1:0]  pe_o1, pe_o2, pe_o3, pe_o4;
  logic [ACC_W-1:0]  res_o1, res_o2, res_o3, res_o4;

  logic [ACC_W-1:0]  acc [4];
  logic [ACC_W-1:0]  w [4];
  logic [7:0]        ref_mem [DEPTH_P];
  int                n_tests = 0;
  int                n_fail = 0;

  always #5 clk = ~clk;

  pe_lin_feeder #(.DATA_W(DATA_W), .ACC_W(ACC_W), .DEPTH(DEPTH_P), .DRAIN(DRAIN_P)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .len(len), .busy(busy), .pe_fire(pe_fire), .pe_a(pe_a),
    .pe_o1(pe_o1), .pe_o2(pe_o2), .pe_o3(pe_o3), .pe_o4(pe_o4),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_o1(res_o1), .res_o2(res_o2), .res_o3(res_o3), .res_o4(res_o4)
  );

  // Behavioural PE_Lin: each accumulator adds weight*a on every fire cycle.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (pe_clr) acc[i] <= '0;
      else if (pe_fire) acc[i] <= acc[i] + w[i] * {4'd0, pe_a};
    end
  end
  assign pe_o1 = acc[0];
  assign pe_o2 = acc[1];
  assign pe_o3 = acc[2];
  assign pe_o4 = acc[3];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic write_buf(input logic [3:0] addr, input logic [7:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    ref_mem[addr] = data;
  endtask

  task automatic check_res(input string tag, input logic [ACC_W-1:0] e [4]);
    check_val({tag, "_o1"}, 32'(res_o1), 32'(e[0]));
    check_val({tag, "_o2"}, 32'(res_o2), 32'(e[1]));
    check_val({tag, "_o3"}, 32'(res_o3), 32'(e[2]));
    check_val({tag, "_o4"}, 32'(res_o4), 32'(e[3]));
  endtask

  // One complete run from a negedge in IDLE; model: stream buf[0..min(l,16)-1], result = w*sum.
  task automatic do_run(input int l, input int rdy_dly, input bit wr_start,
                        input logic [7:0] wdat, input bit wr_mid);
    int lc, first_valid, sum;
    logic [ACC_W-1:0] exp_o [4];
    lc = (l > DEPTH_P) ? DEPTH_P : l;
    pe_clr = 1'b1;
    @(negedge clk);
    pe_clr = 1'b0;
    start = 1'b1; len = 5'(l);
    if (wr_start) begin
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = wdat; ref_mem[0] = wdat;
    end
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    sum = 0;
    for (int i = 0; i < lc; i++) sum += int'(ref_mem[i]);
    for (int i = 0; i < 4; i++) exp_o[i] = ACC_W'(int'(w[i]) * sum);
    if (lc == 0) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check_val("len0_busy", 32'(busy), 32'd0);
        check_val("len0_fire", 32'(pe_fire), 32'd0);
      end
      return;
    end
    first_valid = 0;
    for (int c = 1; c <= lc + DRAIN_P + 4 && first_valid == 0; c++) begin
      @(negedge clk);
      wr_en = 1'b0;
      if (res_valid) begin
        first_valid = c;
      end else begin
        check_val("fire", 32'(pe_fire), 32'(c <= lc));
        check_val("busy", 32'(busy), 32'd1);
        check_val("pe_a", 32'(pe_a), (c <= lc) ? 32'(ref_mem[c-1]) : 32'd0);
        if (wr_mid && c == 2) begin
          wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'd99;
        end
      end
    end
    wr_en = 1'b0;
    check_val("latency", 32'(first_valid), 32'(lc + DRAIN_P + 1));
    if (first_valid == 0) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    check_res("res", exp_o);
    for (int k = 0; k < rdy_dly; k++) begin
      start = (k == 1);
      len = 5'd5;
      @(negedge clk);
      start = 1'b0;
      check_val("hold_valid", 32'(res_valid), 32'd1);
      check_val("hold_busy", 32'(busy), 32'd1);
      check_val("hold_o4", 32'(res_o4), 32'(exp_o[3]));
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check_val("ack_valid", 32'(res_valid), 32'd0);
    check_val("ack_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check_val("no_queue", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [ACC_W-1:0] zero_o [4];
    rst = 1'b1; wr_en = 1'b0; start = 1'b0; res_ready = 1'b0; pe_clr = 1'b1;
    wr_addr = 4'd0; wr_data = 8'd0; len = 5'd0;
    for (int i = 0; i < 4; i++) begin w[i] = ACC_W'(i + 1); zero_o[i] = '0; end
    repeat (2) @(negedge clk);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_fire", 32'(pe_fire), 32'd0);
    check_val("rst_pe_a", 32'(pe_a), 32'd0);
    check_val("rst_valid", 32'(res_valid), 32'd0);
    check_res("rst", zero_o);
    rst = 1'b0; pe_clr = 1'b0;

    // Single run and backpressure on buffer 1..8, weights 1..4.
    for (int i = 0; i < 8; i++) write_buf(4'(i), 8'(i + 1));
    do_run(8, 0, 1'b0, 8'd0, 1'b0);
    do_run(8, 5, 1'b0, 8'd0, 1'b0);

    // Boundaries, with res_ready held high across the ignored len=0 start.
    res_ready = 1'b1;
    do_run(0, 0, 1'b0, 8'd0, 1'b0);
    res_ready = 1'b0;
    write_buf(4'd0, 8'd7);
    do_run(1, 0, 1'b0, 8'd0, 1'b0);
    for (int i = 8; i < DEPTH_P; i++) write_buf(4'(i), 8'($urandom_range(0, 255)));
    do_run(31, 2, 1'b0, 8'd0, 1'b0);

    // Writes during a run are dropped; an IDLE write and a same-cycle start write land.
    do_run(8, 0, 1'b0, 8'd0, 1'b1);
    do_run(8, 0, 1'b0, 8'd0, 1'b0);
    write_buf(4'd0, 8'd99);
    do_run(4, 0, 1'b0, 8'd0, 1'b0);
    do_run(3, 1, 1'b1, 8'd42, 1'b0);

    // Reset at the third streaming cycle.
    start = 1'b1; len = 5'd8;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("mid_rst_fire", 32'(pe_fire), 32'd0);
    check_val("mid_rst_pe_a", 32'(pe_a), 32'd0);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_valid", 32'(res_valid), 32'd0);
    check_val("mid_rst_o1", 32'(res_o1), 32'd0);
    do_run(8, 0, 1'b0, 8'd0, 1'b0);

    // Randomized runs.
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < 4; k++) write_buf(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      for (int i = 0; i < 4; i++) w[i] = ACC_W'($urandom_range(0, 15));
      do_run(int'($urandom_range(0, 31)), int'($urandom_range(0, 4)),
             1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_lin_feeder.md
# pe_lin_feeder

Sequencer that drives one linear processing element (PE_Lin) from the activation side and collects its four accumulator outputs. A host fills a small activation buffer, then pulses `start`. The feeder streams `len` activations on `pe_a` with `pe_fire` high, drops `fire`, and waits a fixed drain interval. It then captures `o1..o4` into a result register and offers the result on a valid/ready handshake. It sits between the host/control logic and a PE_Lin instance, which owns the weights.

## Interface
Parameters:
- `DATA_W`, 8: activation width (matches PE `a`).
- `ACC_W`, 12: PE accumulator width (matches PE `o1..o4`).
- `DEPTH`, 16: activation buffer entries (power of two).
- `DRAIN`, 2: cycles with `fire` low before capture (≥1; covers PE output latency).

Ports:
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  write strobe for the activation buffer.
- `wr_addr`  in  $clog2(DEPTH)  buffer write address.
- `wr_data`  in  DATA_W  buffer write data.
- `start`  in  1  begin a run; sampled only in IDLE.
- `len`  in  $clog2(DEPTH)+1  activations to stream; sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `pe_fire`  out  1  to PE `fire`.
- `pe_a`  out  DATA_W  to PE `a`.
- `pe_o1..pe_o4`  in  ACC_W each  from PE `o1..o4`.
- `res_valid`  out  1  captured result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_o1..res_o4`  out  ACC_W each  captured PE outputs.

## Operation
- FSM states: IDLE, STREAM, DRAIN, HOLD.
- IDLE:
  - `start`=1 with `len`≠0 → STREAM. Index cleared; `len` latched, clamped to DEPTH when larger.
  - `start` with `len`=0 is ignored.
- STREAM:
  - Each cycle: `pe_fire`=1, `pe_a`=buf[idx], idx++.
  - After `len` cycles → DRAIN.
- DRAIN:
  - `pe_fire`=0, `pe_a`=0 for DRAIN cycles (down-counter).
  - On the last drain edge, `pe_o1..4` are captured into `res_o1..4` → HOLD.
- HOLD:
  - `res_valid`=1; `res_o*` stable.
  - `res_valid & res_ready` at an edge → IDLE.
- Buffer writes: accepted only in IDLE; `wr_en` in any other state is dropped.
  - Same-cycle `wr_en` and `start` in IDLE: the write completes, and the run reads the written value if that address is streamed.
- `start` outside IDLE is ignored (no queueing).
- The PE accumulates across runs unless reset. Clearing the PE is the system's job, not the feeder's.
- Arithmetic: no arithmetic on PE data; `res_o*` are bit-exact copies. Index and counter widths are sized so they never wrap inside a legal run.

## Timing
- Reset values (in effect the cycle after `rst` high): state IDLE; `busy`, `pe_fire`, `res_valid` = 0; `pe_a`, `res_o1..4` = 0. Buffer contents are not cleared.
- `rst` mid-run aborts immediately, with no partial result, and returns to IDLE with the reset values above.
- All outputs are registered.
- `start` sampled at edge E:
  - `busy` and `pe_fire` go high in the cycle after E.
  - `pe_a` = buf[0..len-1] in cycles E+1 .. E+len.
- `pe_fire` is low in cycles E+len+1 .. E+len+DRAIN.
- Capture happens at the edge ending cycle E+len+DRAIN. `res_valid` is high from cycle E+len+DRAIN+1.
- Latency from start to `res_valid` = len+DRAIN+1 cycles.
- `res_valid` falls, and `busy` falls, the cycle after the handshake edge. A new `start` is accepted from that cycle.
- `res_ready` held high while IDLE has no effect.

## Structure
- Shared package `pe_lin_pkg`: `DATA_W`, `ACC_W` defaults and the state enum `feeder_state_t` (IDLE, STREAM, DRAIN, HOLD). These are shared with PE_Lin and its benches.
- One sub-module: `act_buf`, a DEPTH×DATA_W register array with one write port and one combinational read port.
- FSM, index counter, drain counter and result registers live in `pe_lin_feeder`.

## Test plan
- **Single run.** Buffer = 1..8, PE weights 1,2,3,4, `len`=8, `res_ready`=1.
  - `pe_a` = 1..8 on consecutive cycles with `fire`=1.
  - `res_o` = 36,72,108,144, `res_valid` exactly 11 cycles after start (DRAIN=2).
- **Backpressure.** Same run with `res_ready` low for 5 cycles after `res_valid`.
  - `res_o` holds 36,72,108,144; `busy` stays 1; a `start` pulsed during HOLD is ignored.
- **Boundaries.**
  - `len`=0 → no state change, `busy`=0.
  - `len`=1, buf[0]=7 → one `fire` cycle, `res_o` = 7,14,21,28.
  - `len`=31 → clamped; exactly 16 `fire` cycles.
- **Write blocking.** `wr_en` to addr 0 with data 99 during STREAM.
  - Current and next run both stream the original buf[0]; the same write issued in IDLE takes effect.
- **Reset mid-run.** `rst` at the 3rd STREAM cycle.
  - Next cycle: `pe_fire`=0, `pe_a`=0, `busy`=0, `res_valid`=0.
  - A subsequent run works normally with buffer contents intact.
